key_mixing: RTL and testbench
=============================

Name: key_mixing

Overview:
RC5 key-schedule mixing stage. It sits directly downstream of the S-table initialisation stage. Once the S table holds P/Q-initialised words, this block runs the 3·max(T,C) mixing passes over S and the key-word array L, rewriting both memories in place:
- A = S[i] = (S[i]+A+B) <<< 3
- B = L[j] = (L[j]+A+B) <<< (A+B)

Its oDone releases the encrypt/decrypt datapath.

Parameters:
- T, 16, number of S-table words (2r+2).
- C, 4, number of key words in L (≥1).
- W, 32, word width in bits; must be a power of two.
- N, 3*max(T,C), total mixing iterations (derived; do not override).
- T_LENGTH, $clog2(T), S address width.
- C_LENGTH, max(1,$clog2(C)), L address width.
- N_LENGTH, $clog2(N+1), iteration counter width.
- ROT_LENGTH, $clog2(W), rotate-amount width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- iStart, in, 1, start request; sampled only in IDLE (tied to the S-init oDone).
- iS_data, in, W, S RAM read data; 1-cycle synchronous read.
- oS_address, out, T_LENGTH, S RAM address.
- oS_data, out, W, S RAM write data.
- oS_we, out, 1, S RAM write enable.
- iL_data, in, W, L RAM read data; 1-cycle synchronous read.
- oL_address, out, C_LENGTH, L RAM address.
- oL_data, out, W, L RAM write data.
- oL_we, out, 1, L RAM write enable.
- oBusy, out, 1, high from ADDR through NEXT.
- oDone, out, 1, sticky completion flag.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; A=B=0; i=j=k=0; every output 0.
- Reset mid-operation: abort immediately to IDLE with all outputs 0. Partially mixed RAM contents are not restored; the upstream stage must rerun.
- FSM, with per-state action and next state:
  - IDLE: if iStart, clear A,B,i,j,k -> ADDR; else stay.
  - ADDR: oS_address=i, oL_address=j, both we=0 -> WAIT.
  - WAIT: RAM samples the address -> READ.
  - READ: capture rS=iS_data, rL=iL_data -> CALC_A.
  - CALC_A: A=rotl(rS+A+B, 3); oS_data=new A -> WR_S.
  - WR_S: oS_we=1 for exactly this cycle; address and data stable -> CALC_B.
  - CALC_B: B=rotl(rL+A+B, (A+B)[ROT_LENGTH-1:0]), using the new A; oL_data=new B -> WR_L.
  - WR_L: oL_we=1 for exactly this cycle -> NEXT.
  - NEXT: i = (i==T-1) ? 0 : i+1; j = (j==C-1) ? 0 : j+1; k=k+1. If k==N-1 -> DONE, else -> ADDR.
  - DONE: oDone=1, oBusy=0, both we=0. Stay until rst.
- Timing: call the cycle in which iStart is sampled high cycle 0. Iteration n (0-based) then runs:
  - ADDR at cycle 8n+1;
  - oS_we high at cycle 8n+5;
  - oL_we high at cycle 8n+7;
  - NEXT at cycle 8n+8.
  - oDone rises at cycle 8N+1 (385 for defaults).
- Write enables: oS_we and oL_we are never high together and never high outside WR_S/WR_L.
- Arithmetic: all adds are modulo 2^W. Rotate amount 0 returns the operand unchanged; amount W-1 is legal.
- Index wrap: i and j wrap independently, e.g. T=4, C=3 gives an L index sequence 0,1,2,0,1,...
- iStart while busy or in DONE: ignored; no restart without rst. iStart and rst high together: rst wins.

Decomposition:
- Shared package rc5_pkg holds:
  - state encodings (IDLE..DONE, 4-bit);
  - default W/T/C and the P/Q constants shared with S-init;
  - function rotl(value, amount) for W-bit rotate-left.
- Natural sub-module: rc5_rotl, a combinational W-bit barrel rotator with a ROT_LENGTH-bit amount. Instantiate it twice (fixed 3, and variable), and reuse it later in the encrypt round.

Test Plan:
- Reset and idle: hold rst 3 cycles, keep iStart=0 for 20 cycles -> all outputs 0, state stays IDLE, no write enable ever high.
- Arithmetic: T=2, C=1, W=32, S={1,0}, L={0}, pulse iStart.
  - First two S writes: 0x00000008 at address 0, then 0x00004040 at address 1.
  - First two L writes at address 0: 0x00000800, then 0x00005040 (rotate amount 0x4840&31=0 exercises the zero-rotate case).
- Full default run: T=16, C=4, W=32, S loaded by S-init, L=0.
  - oS_we high at cycles 5, 13, ...; oL_we high at cycles 7, 15, ...
  - oDone rises at cycle 385, with exactly 48 writes to each memory.
  - Final RAM contents match the software golden model bit-exactly.
- Wrap: T=4, C=3 (N=12):
  - oS_address per iteration 0,1,2,3,0,1,...
  - oL_address per iteration 0,1,2,0,1,2,...
  - oDone rises at cycle 97.
- Rotate 31: preload so that A+B = 0x1F at CALC_B with rL+A+B=0x00000001 -> oL_data=0x80000000.
- Control corners:
  - iStart pulses during the run and in DONE -> no effect; write count unchanged.
  - rst asserted at cycle 30 -> outputs 0 the next cycle.
  - Rerunning with iStart afterwards repeats the cycle-exact timeline from cycle 0.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: controller state encoding, default geometry,
// the magic constants shared with the S-table initialisation stage, and
// a W_DEF-bit rotate-left helper.
package rc5_pkg;

  localparam int W_DEF = 32;
  localparam int T_DEF = 16;
  localparam int C_DEF = 4;

  // RC5 magic constants for 32-bit words.
  localparam logic [31:0] P32 = 32'hB7E1_5163;
  localparam logic [31:0] Q32 = 32'h9E37_79B9;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_WAIT   = 4'd2,
    ST_READ   = 4'd3,
    ST_CALC_A = 4'd4,
    ST_WR_S   = 4'd5,
    ST_CALC_B = 4'd6,
    ST_WR_L   = 4'd7,
    ST_NEXT   = 4'd8,
    ST_DONE   = 4'd9
  } state_e;

  // Rotate-left of a default-width word; amount 0 returns the operand.
  function automatic logic [W_DEF-1:0] rotl(input logic [W_DEF-1:0]         value,
                                            input logic [$clog2(W_DEF)-1:0] amount);
    logic [$clog2(W_DEF):0] inv;
    inv = ($clog2(W_DEF)+1)'(W_DEF) - {1'b0, amount};
    return (value << amount) | (value >> inv);
  endfunction

endpackage

// File: rtl/rc5_rotl.sv
// Combinational W-bit barrel rotate-left. Shared by the key-mixing stage
// and the encrypt/decrypt rounds.
module rc5_rotl #(
  parameter int W          = 32,
  parameter int ROT_LENGTH = $clog2(W)
) (
  input  logic [W-1:0]          din,
  input  logic [ROT_LENGTH-1:0] amount,
  output logic [W-1:0]          dout
);

  logic [ROT_LENGTH:0] inv;

  // Left part shifts up, wrapped part comes down by W-amount; with amount
  // zero the right shift is by W and contributes nothing.
  always_comb begin
    inv  = (ROT_LENGTH+1)'(W) - {1'b0, amount};
    dout = (din << amount) | (din >> inv);
  end

endmodule

// File: rtl/key_mixing.sv
// RC5 key-schedule mixing stage. Runs 3*max(T,C) passes over the S table
// and key-word array L, rewriting both RAMs in place. Each pass takes eight
// cycles: address, RAM latency, capture, compute A, write S, compute B,
// write L, advance indices.
module key_mixing
  import rc5_pkg::*;
#(
  parameter  int T          = T_DEF,
  parameter  int C          = C_DEF,
  parameter  int W          = W_DEF,
  localparam int N          = 3 * ((T > C) ? T : C),
  localparam int T_LENGTH   = $clog2(T),
  localparam int C_LENGTH   = (C > 1) ? $clog2(C) : 1,
  localparam int N_LENGTH   = $clog2(N + 1),
  localparam int ROT_LENGTH = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [W-1:0]        iS_data,
  output logic [T_LENGTH-1:0] oS_address,
  output logic [W-1:0]        oS_data,
  output logic                oS_we,
  input  logic [W-1:0]        iL_data,
  output logic [C_LENGTH-1:0] oL_address,
  output logic [W-1:0]        oL_data,
  output logic                oL_we,
  output logic                oBusy,
  output logic                oDone
);

  state_e              state_q, state_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [W-1:0]        rs_q, rs_d, rl_q, rl_d;
  logic [T_LENGTH-1:0] i_q, i_d;
  logic [C_LENGTH-1:0] j_q, j_d;
  logic [N_LENGTH-1:0] k_q, k_d;
  logic [T_LENGTH-1:0] s_addr_q, s_addr_d;
  logic [C_LENGTH-1:0] l_addr_q, l_addr_d;
  logic [W-1:0]        s_data_q, s_data_d, l_data_q, l_data_d;
  logic                s_we_q, s_we_d, l_we_q, l_we_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [W-1:0]        sum_a, ab_sum, sum_b, rot_a, rot_b;

  // A takes the fresh S word; B uses A as already updated in CALC_A.
  assign sum_a  = rs_q + a_q + b_q;
  assign ab_sum = a_q + b_q;
  assign sum_b  = rl_q + ab_sum;

  rc5_rotl #(.W(W), .ROT_LENGTH(ROT_LENGTH)) u_rot_a (
    .din    (sum_a),
    .amount (ROT_LENGTH'(3)),
    .dout   (rot_a)
  );

  rc5_rotl #(.W(W), .ROT_LENGTH(ROT_LENGTH)) u_rot_b (
    .din    (sum_b),
    .amount (ab_sum[ROT_LENGTH-1:0]),
    .dout   (rot_b)
  );

  // Next-state, datapath update, and registered-output decode of the next state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rs_d     = rs_q;
    rl_d     = rl_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    s_addr_d = s_addr_q;
    l_addr_d = l_addr_q;
    s_data_d = s_data_q;
    l_data_d = l_data_q;

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d     = '0;
          b_d     = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR:   state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_READ;
      ST_READ: begin
        rs_d    = iS_data;
        rl_d    = iL_data;
        state_d = ST_CALC_A;
      end
      ST_CALC_A: begin
        a_d      = rot_a;
        s_data_d = rot_a;
        state_d  = ST_WR_S;
      end
      ST_WR_S:   state_d = ST_CALC_B;
      ST_CALC_B: begin
        b_d      = rot_b;
        l_data_d = rot_b;
        state_d  = ST_WR_L;
      end
      ST_WR_L:   state_d = ST_NEXT;
      ST_NEXT: begin
        i_d     = (i_q == T_LENGTH'(T - 1)) ? '0 : i_q + T_LENGTH'(1);
        j_d     = (j_q == C_LENGTH'(C - 1)) ? '0 : j_q + C_LENGTH'(1);
        k_d     = k_q + N_LENGTH'(1);
        state_d = (k_q == N_LENGTH'(N - 1)) ? ST_DONE : ST_ADDR;
      end
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    s_we_d = (state_d == ST_WR_S);
    l_we_d = (state_d == ST_WR_L);
    busy_d = (state_d inside {[ST_ADDR:ST_NEXT]});
    done_d = (state_d == ST_DONE);
    if (state_d == ST_ADDR) begin
      s_addr_d = i_d;
      l_addr_d = j_d;
    end
  end

  // State and output registers with synchronous reset that aborts any pass.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge value of every other.
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rs_q     <= '0;
      rl_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      s_addr_q <= '0;
      l_addr_q <= '0;
      s_data_q <= '0;
      l_data_q <= '0;
      s_we_q   <= 1'b0;
      l_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rs_q     <= rs_d;
      rl_q     <= rl_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      s_addr_q <= s_addr_d;
      l_addr_q <= l_addr_d;
      s_data_q <= s_data_d;
      l_data_q <= l_data_d;
      s_we_q   <= s_we_d;
      l_we_q   <= l_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign oS_address = s_addr_q;
  assign oS_data    = s_data_q;
  assign oS_we      = s_we_q;
  assign oL_address = l_addr_q;
  assign oL_data    = l_data_q;
  assign oL_we      = l_we_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_key_mixing.sv
// Scoreboard bench for key_mixing. Three instances: A (T=2,C=1) for the
// hand-computed arithmetic and rotate-31 vectors, D (T=16,C=4) for the full
// default run, reset abort and rerun, W (T=4,C=3) for independent index wrap.
// Expected writes (relative cycle, address, data) are queued at stimulus
// time; negedge monitors pop and compare on every write enable.
module tb_key_mixing;
  import rc5_pkg::*;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start_a, start_d, start_w, load;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A: T=2, C=1 ----------------
  logic [31:0] s_rd_a, l_rd_a, s_wd_a, l_wd_a;
  logic [0:0]  s_ad_a, l_ad_a;
  logic        s_we_a, l_we_a, busy_a, done_a;
  logic [31:0] s_mem_a [2], pre_s_a [2];
  logic [31:0] l_mem_a [1], pre_l_a [1];

  key_mixing #(.T(2), .C(1), .W(32)) u_dut_a (
    .clk(clk), .rst(rst), .iStart(start_a),
    .iS_data(s_rd_a), .oS_address(s_ad_a), .oS_data(s_wd_a), .oS_we(s_we_a),
    .iL_data(l_rd_a), .oL_address(l_ad_a), .oL_data(l_wd_a), .oL_we(l_we_a),
    .oBusy(busy_a), .oDone(done_a)
  );

  always @(posedge clk) begin
    if (load) begin
      s_mem_a <= pre_s_a;
      l_mem_a <= pre_l_a;
    end else begin
      if (s_we_a) s_mem_a[s_ad_a] <= s_wd_a;
      if (l_we_a) l_mem_a[l_ad_a] <= l_wd_a;
    end
    s_rd_a <= s_mem_a[s_ad_a];
    l_rd_a <= l_mem_a[l_ad_a];
  end

  // ---------------- instance D: T=16, C=4 ----------------
  logic [31:0] s_rd_d, l_rd_d, s_wd_d, l_wd_d;
  logic [3:0]  s_ad_d;
  logic [1:0]  l_ad_d;
  logic        s_we_d, l_we_d, busy_d, done_d;
  logic [31:0] s_mem_d [16], pre_s_d [16];
  logic [31:0] l_mem_d [4], pre_l_d [4];

  key_mixing #(.T(16), .C(4), .W(32)) u_dut_d (
    .clk(clk), .rst(rst), .iStart(start_d),
    .iS_data(s_rd_d), .oS_address(s_ad_d), .oS_data(s_wd_d), .oS_we(s_we_d),
    .iL_data(l_rd_d), .oL_address(l_ad_d), .oL_data(l_wd_d), .oL_we(l_we_d),
    .oBusy(busy_d), .oDone(done_d)
  );

  always @(posedge clk) begin
    if (load) begin
      s_mem_d <= pre_s_d;
      l_mem_d <= pre_l_d;
    end else begin
      if (s_we_d) s_mem_d[s_ad_d] <= s_wd_d;
      if (l_we_d) l_mem_d[l_ad_d] <= l_wd_d;
    end
    s_rd_d <= s_mem_d[s_ad_d];
    l_rd_d <= l_mem_d[l_ad_d];
  end

  // ---------------- instance W: T=4, C=3 ----------------
  logic [31:0] s_rd_w, l_rd_w, s_wd_w, l_wd_w;
  logic [1:0]  s_ad_w, l_ad_w;
  logic        s_we_w, l_we_w, busy_w, done_w;
  logic [31:0] s_mem_w [4], pre_s_w [4];
  logic [31:0] l_mem_w [3], pre_l_w [3];

  key_mixing #(.T(4), .C(3), .W(32)) u_dut_w (
    .clk(clk), .rst(rst), .iStart(start_w),
    .iS_data(s_rd_w), .oS_address(s_ad_w), .oS_data(s_wd_w), .oS_we(s_we_w),
    .iL_data(l_rd_w), .oL_address(l_ad_w), .oL_data(l_wd_w), .oL_we(l_we_w),
    .oBusy(busy_w), .oDone(done_w)
  );

  always @(posedge clk) begin
    if (load) begin
      s_mem_w <= pre_s_w;
      l_mem_w <= pre_l_w;
    end else begin
      if (s_we_w) s_mem_w[s_ad_w] <= s_wd_w;
      if (l_we_w) l_mem_w[l_ad_w] <= l_wd_w;
    end
    s_rd_w <= s_mem_w[s_ad_w];
    l_rd_w <= l_mem_w[l_ad_w];
  end

  // ---------------- scoreboard state ----------------
  wr_t sq_a[$], lq_a[$], sq_d[$], lq_d[$], sq_w[$], lq_w[$];
  int  t0_a = 0, t0_d = 0, t0_w = 0;
  int  done_cyc_a = -1, done_cyc_d = -1, done_cyc_w = -1;
  int  nws_a = 0, nwl_a = 0, nws_d = 0, nwl_d = 0, nws_w = 0, nwl_w = 0;
  bit  run_d = 1'b0;

  // Golden model scratch
  logic [31:0] m_s[], m_l[];
  wr_t         m_sq[$], m_lq[$];
  logic [31:0] exp_s_a[], exp_l_a[], exp_s_d[], exp_l_d[], exp_s_w[], exp_l_w[];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string nm, input int rel);
    n_checks++;
    n_fail++;
    $display("FAIL %s: write enable high at rel cycle %0d, expected no write", nm, rel);
  endtask

  task automatic cmp_wr(input string nm, input int rel, input int addr,
                        input logic [31:0] data, input wr_t e);
    n_checks++;
    if (rel != e.cyc || addr != e.addr || data !== e.data) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d addr=%0d data=%08h, expected cyc=%0d addr=%0d data=%08h",
               nm, rel, addr, data, e.cyc, e.addr, e.data);
    end
  endtask

  function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int amt);
    if (amt == 0) return x;
    return (x << amt) | (x >> (32 - amt));
  endfunction

  // Software RC5 mixing over m_s/m_l; records each write with its relative cycle.
  task automatic run_model(input int t, input int c);
    logic [31:0] a, b;
    int i, j, n;
    a = '0; b = '0; i = 0; j = 0;
    n = 3 * ((t > c) ? t : c);
    m_sq.delete();
    m_lq.delete();
    for (int k = 0; k < n; k++) begin
      a = ref_rotl(m_s[i] + a + b, 3);
      m_s[i] = a;
      m_sq.push_back('{8*k + 5, i, a});
      b = ref_rotl(m_l[j] + a + b, int'((a + b) & 32'd31));
      m_l[j] = b;
      m_lq.push_back('{8*k + 7, j, b});
      i = (i + 1) % t;
      j = (j + 1) % c;
    end
  endtask

  task automatic init_pq(input int t);
    m_s = new[t];
    m_s[0] = P32;
    for (int i = 1; i < t; i++) m_s[i] = m_s[i-1] + Q32;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    bit dprev_a;
    if (s_we_a && l_we_a) fail_unexpected("a_both_we", cyc - t0_a);
    if (s_we_a) begin
      nws_a++;
      if (sq_a.size() == 0) fail_unexpected("a_s_wr", cyc - t0_a);
      else cmp_wr("a_s_wr", cyc - t0_a, int'(s_ad_a), s_wd_a, sq_a.pop_front());
    end
    if (l_we_a) begin
      nwl_a++;
      if (lq_a.size() == 0) fail_unexpected("a_l_wr", cyc - t0_a);
      else cmp_wr("a_l_wr", cyc - t0_a, int'(l_ad_a), l_wd_a, lq_a.pop_front());
    end
    if (done_a === 1'b1 && !dprev_a) done_cyc_a = cyc - t0_a;
    dprev_a = (done_a === 1'b1);
  end

  always @(negedge clk) begin
    bit dprev_d;
    int rel;
    rel = cyc - t0_d;
    if (s_we_d && l_we_d) fail_unexpected("d_both_we", rel);
    if (s_we_d) begin
      nws_d++;
      if (sq_d.size() == 0) fail_unexpected("d_s_wr", rel);
      else cmp_wr("d_s_wr", rel, int'(s_ad_d), s_wd_d, sq_d.pop_front());
    end
    if (l_we_d) begin
      nwl_d++;
      if (lq_d.size() == 0) fail_unexpected("d_l_wr", rel);
      else cmp_wr("d_l_wr", rel, int'(l_ad_d), l_wd_d, lq_d.pop_front());
    end
    if (run_d) check("d_busy", 64'(busy_d), 64'(rel >= 1 && rel <= 384));
    if (done_d === 1'b1 && !dprev_d) done_cyc_d = rel;
    dprev_d = (done_d === 1'b1);
  end

  always @(negedge clk) begin
    bit dprev_w;
    if (s_we_w && l_we_w) fail_unexpected("w_both_we", cyc - t0_w);
    if (s_we_w) begin
      nws_w++;
      if (sq_w.size() == 0) fail_unexpected("w_s_wr", cyc - t0_w);
      else cmp_wr("w_s_wr", cyc - t0_w, int'(s_ad_w), s_wd_w, sq_w.pop_front());
    end
    if (l_we_w) begin
      nwl_w++;
      if (lq_w.size() == 0) fail_unexpected("w_l_wr", cyc - t0_w);
      else cmp_wr("w_l_wr", cyc - t0_w, int'(l_ad_w), l_wd_w, lq_w.pop_front());
    end
    if (done_w === 1'b1 && !dprev_w) done_cyc_w = cyc - t0_w;
    dprev_w = (done_w === 1'b1);
  end

  task automatic check_zero(input string tag);
    check({tag, "_a_data"}, {s_wd_a, l_wd_a}, 64'd0);
    check({tag, "_a_ctl"}, 64'({s_ad_a, l_ad_a, s_we_a, l_we_a, busy_a, done_a}), 64'd0);
    check({tag, "_d_data"}, {s_wd_d, l_wd_d}, 64'd0);
    check({tag, "_d_ctl"}, 64'({s_ad_d, l_ad_d, s_we_d, l_we_d, busy_d, done_d}), 64'd0);
    check({tag, "_w_data"}, {s_wd_w, l_wd_w}, 64'd0);
    check({tag, "_w_ctl"}, 64'({s_ad_w, l_ad_w, s_we_w, l_we_w, busy_w, done_w}), 64'd0);
  endtask

  // Loads D with P/Q-initialised S and zero L, and queues its golden writes.
  task automatic prep_d();
    init_pq(16);
    m_l = new[4];
    foreach (m_l[i]) m_l[i] = '0;
    foreach (pre_s_d[i]) pre_s_d[i] = m_s[i];
    foreach (pre_l_d[i]) pre_l_d[i] = m_l[i];
    run_model(16, 4);
    sq_d = m_sq;
    lq_d = m_lq;
    exp_s_d = m_s;
    exp_l_d = m_l;
  endtask

  task automatic check_final_d(input string tag);
    foreach (exp_s_d[i]) check({tag, "_s_final"}, 64'(s_mem_d[i]), 64'(exp_s_d[i]));
    foreach (exp_l_d[i]) check({tag, "_l_final"}, 64'(l_mem_d[i]), 64'(exp_l_d[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start_a = 1'b0; start_d = 1'b0; start_w = 1'b0; load = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset and idle: outputs stay 0 with iStart low.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_d_data", {s_wd_d, l_wd_d}, 64'd0);
      check("idle_d_ctl", 64'({s_ad_d, l_ad_d, s_we_d, l_we_d, busy_d, done_d}), 64'd0);
    end
    check_zero("idle");

    // A: S={1,0}, L={0}; first two passes are hand-computed.
    m_s = new[2]; m_s[0] = 32'd1; m_s[1] = 32'd0;
    m_l = new[1]; m_l[0] = 32'd0;
    foreach (pre_s_a[i]) pre_s_a[i] = m_s[i];
    foreach (pre_l_a[i]) pre_l_a[i] = m_l[i];
    run_model(2, 1);
    m_sq[0] = '{5, 0, 32'h0000_0008};
    m_sq[1] = '{13, 1, 32'h0000_4040};
    m_lq[0] = '{7, 0, 32'h0000_0800};
    m_lq[1] = '{15, 0, 32'h0000_5040};
    sq_a = m_sq; lq_a = m_lq; exp_s_a = m_s; exp_l_a = m_l;

    prep_d();

    // W: T=4, C=3 with distinct key bytes.
    init_pq(4);
    m_l = new[3];
    m_l[0] = 32'h0302_0100; m_l[1] = 32'h0706_0504; m_l[2] = 32'h0B0A_0908;
    foreach (pre_s_w[i]) pre_s_w[i] = m_s[i];
    foreach (pre_l_w[i]) pre_l_w[i] = m_l[i];
    run_model(4, 3);
    sq_w = m_sq; lq_w = m_lq; exp_s_w = m_s; exp_l_w = m_l;

    load = 1'b1; tick(); load = 1'b0; tick();

    start_a = 1'b1; start_d = 1'b1; start_w = 1'b1;
    t0_a = cyc; t0_d = cyc; t0_w = cyc; run_d = 1'b1;
    for (int r = 1; r <= 400; r++) begin
      tick();
      // Pulses at 100/200 hit D busy and A/W in DONE; 390 hits D in DONE.
      start_a = (r == 100 || r == 200 || r == 390);
      start_d = start_a;
      start_w = start_a;
    end
    start_a = 1'b0; start_d = 1'b0; start_w = 1'b0;
    repeat (10) tick();

    check("a_done_cycle", 64'(done_cyc_a), 64'd49);
    check("d_done_cycle", 64'(done_cyc_d), 64'd385);
    check("w_done_cycle", 64'(done_cyc_w), 64'd97);
    check("a_wr_count", 64'({nws_a, nwl_a}), {32'd6, 32'd6});
    check("d_wr_count", 64'({nws_d, nwl_d}), {32'd48, 32'd48});
    check("w_wr_count", 64'({nws_w, nwl_w}), {32'd12, 32'd12});
    check("sb_left", 64'(sq_a.size() + lq_a.size() + sq_d.size() + lq_d.size()
                         + sq_w.size() + lq_w.size()), 64'd0);
    check("d_done_hold", 64'({done_d, busy_d, s_we_d, l_we_d}), 64'b1000);
    foreach (exp_s_a[i]) check("a_s_final", 64'(s_mem_a[i]), 64'(exp_s_a[i]));
    foreach (exp_l_a[i]) check("a_l_final", 64'(l_mem_a[i]), 64'(exp_l_a[i]));
    foreach (exp_s_w[i]) check("w_s_final", 64'(s_mem_w[i]), 64'(exp_s_w[i]));
    foreach (exp_l_w[i]) check("w_l_final", 64'(l_mem_w[i]), 64'(exp_l_w[i]));
    check_final_d("d");

    // Reset abort of D at relative cycle 30.
    rst = 1'b1; run_d = 1'b0; tick(); rst = 1'b0; tick();
    prep_d();
    load = 1'b1; tick(); load = 1'b0; tick();
    nws_d = 0; nwl_d = 0; done_cyc_d = -1;
    start_d = 1'b1; t0_d = cyc; run_d = 1'b1;
    tick();
    start_d = 1'b0;
    while (cyc - t0_d < 30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; run_d = 1'b0;
    sq_d.delete(); lq_d.delete();
    check("abort_rel_cycle", 64'(cyc - t0_d), 64'd31);
    check_zero("abort");
    check("abort_wr_count", 64'({nws_d, nwl_d}), {32'd4, 32'd3});

    // Rerun D from scratch; A gets the rotate-by-31 vector.
    m_s = new[2]; m_s[0] = 32'hE000_0003; m_s[1] = 32'd0;
    m_l = new[1]; m_l[0] = 32'hFFFF_FFE2;
    foreach (pre_s_a[i]) pre_s_a[i] = m_s[i];
    foreach (pre_l_a[i]) pre_l_a[i] = m_l[i];
    run_model(2, 1);
    m_sq[0] = '{5, 0, 32'h0000_001F};
    m_lq[0] = '{7, 0, 32'h8000_0000};
    sq_a = m_sq; lq_a = m_lq;
    prep_d();
    load = 1'b1; tick(); load = 1'b0; tick();
    nws_a = 0; nwl_a = 0; nws_d = 0; nwl_d = 0; done_cyc_a = -1; done_cyc_d = -1;
    start_a = 1'b1; start_d = 1'b1; t0_a = cyc; t0_d = cyc; run_d = 1'b1;
    tick();
    start_a = 1'b0; start_d = 1'b0;
    repeat (400) tick();

    check("rerun_a_done_cycle", 64'(done_cyc_a), 64'd49);
    check("rerun_d_done_cycle", 64'(done_cyc_d), 64'd385);
    check("rerun_d_wr_count", 64'({nws_d, nwl_d}), {32'd48, 32'd48});
    check("rerun_sb_left", 64'(sq_a.size() + lq_a.size() + sq_d.size() + lq_d.size()), 64'd0);
    check_final_d("rerun_d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
